// File: rtl/oam_dma.sv
// Sprite-DMA engine: forwards CPU bus accesses to the memory controller and, on a
// write to the DMA register, stalls the CPU while it copies one 256-byte page to OAM.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter bit          ALIGN_CYCLE   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_in,
    output logic        mem_write_en,
    output logic        mem_read_en,
    input  logic [7:0]  mem_data_out,
    output logic        dma_active
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] count_q, count_d;

    assign cpu_data_out = mem_data_out;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path
        // through the case statement can infer a latch.
        state_d      = state_q;
        page_d       = page_q;
        count_d      = count_q;
        mem_addr     = cpu_addr_in;
        mem_data_in  = cpu_data_in;
        mem_write_en = cpu_write_en;
        mem_read_en  = cpu_read_en;
        cpu_rdy      = 1'b0;
        dma_active   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
                // The trigger write still reaches memory this cycle via the pass-through.
                if (cpu_write_en && (cpu_addr_in == DMA_REG_ADDR)) begin
                    page_d  = cpu_data_in;
                    count_d = 8'h00;
                    state_d = ALIGN_CYCLE ? ST_ALIGN : ST_READ;
                end
            end
            ST_ALIGN: begin
                mem_addr     = 16'h0000;
                mem_data_in  = 8'h00;
                mem_write_en = 1'b0;
                mem_read_en  = 1'b0;
                state_d      = ST_READ;
            end
            ST_READ: begin
                mem_addr     = {page_q, count_q};
                mem_data_in  = 8'h00;
                mem_write_en = 1'b0;
                mem_read_en  = 1'b1;
                state_d      = ST_WRITE;
            end
            ST_WRITE: begin
                // Byte fetched by the previous READ comes back registered this cycle.
                mem_addr     = OAM_DATA_ADDR;
                mem_data_in  = mem_data_out;
                mem_write_en = 1'b1;
                mem_read_en  = 1'b0;
                if (count_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q + 8'd1;
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA engine placed between the CPU core and `mem_ctrl_1_cycle` on the CPU bus. It passes CPU accesses straight through to the memory controller. A CPU write to the DMA register triggers a copy of one 256-byte CPU page into sprite RAM. The copy is done by driving 256 read/write pairs through `mem_ctrl_1_cycle`'s OAM data port (0x2004) while the CPU is stalled.

## Interface
- `DMA_REG_ADDR`, 16'h4014, CPU address that triggers a DMA.
- `OAM_DATA_ADDR`, 16'h2004, memory-controller address that writes sprite RAM and post-increments its pointer.
- `ALIGN_CYCLE`, 1, number of idle dummy cycles (0 or 1) inserted before the first DMA read.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_addr_in` in 16: CPU address.
- `cpu_data_in` in 8: CPU write data.
- `cpu_write_en` in 1: CPU write strobe.
- `cpu_read_en` in 1: CPU read strobe.
- `cpu_data_out` out 8: read data to CPU, always equal to `mem_data_out`.
- `cpu_rdy` out 1: 0 stalls the CPU core.
- `mem_addr` out 16: address to `mem_ctrl_1_cycle`.
- `mem_data_in` out 8: write data to `mem_ctrl_1_cycle`.
- `mem_write_en` out 1: write strobe to `mem_ctrl_1_cycle`.
- `mem_read_en` out 1: read strobe to `mem_ctrl_1_cycle`.
- `mem_data_out` in 8: registered read data from `mem_ctrl_1_cycle`, valid in the cycle after the read edge.
- `dma_active` out 1: high while the FSM is not in IDLE.

## Operation
- FSM states are IDLE, ALIGN, READ and WRITE.
- Registers:
  - `page[7:0]`: source page.
  - `count[7:0]`: byte index.
  - `state`.
- **IDLE**
  - `mem_addr`, `mem_data_in`, `mem_write_en` and `mem_read_en` are combinational copies of the CPU inputs.
  - `cpu_rdy`=1, `dma_active`=0.
  - On an edge with `cpu_write_en`=1 and `cpu_addr_in`==`DMA_REG_ADDR`:
    - The write itself is still forwarded to memory that cycle.
    - `page`<=`cpu_data_in`, `count`<=0.
    - Next state is ALIGN if `ALIGN_CYCLE`=1, otherwise READ.
- **ALIGN**
  - Bus outputs are driven: addr=0, `mem_write_en`=0, `mem_read_en`=0.
  - Lasts one cycle, then READ.
- **READ**
  - `mem_addr`={`page`,`count`}, `mem_read_en`=1, `mem_write_en`=0.
  - Next state is WRITE.
- **WRITE**
  - `mem_addr`=`OAM_DATA_ADDR`, `mem_data_in`=`mem_data_out` (the byte fetched by the preceding READ), `mem_write_en`=1, `mem_read_en`=0.
  - At the edge: if `count`==8'hFF, go to IDLE; otherwise `count`<=`count`+1 and go to READ.
- In all non-IDLE states: `cpu_rdy`=0, `dma_active`=1, and all CPU inputs are ignored. A second write to `DMA_REG_ADDR` during a DMA is discarded.
- Address arithmetic:
  - `count` is 8-bit and `page` is never incremented.
  - Page 0xFF reads 0xFF00..0xFFFF with no carry into 0x0000.
- Sprite RAM destination offset is wherever the memory controller's OAM pointer (0x2003) currently points. This block does not write 0x2003, so the pointer wraps inside the memory controller.
- Any source page is legal, including PPU register pages; the accesses are forwarded unchanged.

## Timing
- Reset (`rst`=0, asynchronous):
  - `state`=IDLE, `page`=0, `count`=0.
  - `cpu_rdy`=1 and `dma_active`=0 immediately.
  - Bus outputs equal the CPU inputs (pass-through); `cpu_data_out`=`mem_data_out`.
- Trigger edge T0: `cpu_rdy` falls in the cycle after T0.
- The stall lasts `ALIGN_CYCLE`+512 cycles, i.e. 513 with the default.
- The last write to 0x2004 occurs on edge T0+`ALIGN_CYCLE`+512. `cpu_rdy`=1 and pass-through resume in the following cycle.
- Each byte takes 2 cycles with read-to-write latency of 1 edge, matching the 1-cycle registered read of `mem_ctrl_1_cycle`.
- Reset mid-DMA:
  - Abort immediately; the sprite RAM write in progress is suppressed because `mem_write_en` reverts to the CPU value.
  - Partial data already written stays in sprite RAM.
- Trigger during reset: ignored.

## Test plan
1. **Reset and pass-through.** Apply `rst`=0 for 10 cycles, then release. Write CPU 0x0123=0xA5, then read it back. Required: `cpu_rdy`=1 and `dma_active`=0 throughout; read returns 0xA5.
2. **Basic DMA.** Preload RAM 0x0200+i=i for i=0..255, write 0x2003=0x00, then write 0x4014=0x02. Required:
   - `cpu_rdy`=0 for exactly 513 cycles.
   - 256 writes to 0x2004 with data 0x00..0xFF in order.
   - `spram_ppu_data` at address i reads i.
3. **Top page.** Preload 0x7F00+i=~i, write 0x2003=0x10, then write 0x4014=0x7F. Required:
   - Last read address is 0x7FFF, and no access is made to 0x8000 or 0x0000.
   - Sprite RAM (0x10+i) mod 256 holds ~i, confirming wrap in the memory controller.
4. **Reset mid-DMA.** Pull `rst` low during cycle 100 of a DMA. Required: `cpu_rdy`=1 and `dma_active`=0 in the same cycle. A following DMA of page 0x02 completes with full 513-cycle timing and correct data.
5. **Ignored retrigger.** During a DMA of page 0x02, the CPU drives a write 0x4014=0x05. Required: exactly 256 OAM writes, all sourced from page 0x02, and stall length unchanged.
6. **No align cycle.** With `ALIGN_CYCLE`=0, rerun scenario 2. Required: stall of exactly 512 cycles, and the first READ is in the cycle right after T0.
